// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg
// Shared definitions for the j2 sequential ALU: opcode encodings, the FSM
// state type and a helper that sorts an opcode into its execution class
// (single-cycle, iterative multiply or iterative divide).
package seq_alu_pkg;

  localparam logic [4:0] OP_T    = 5'd0;
  localparam logic [4:0] OP_N    = 5'd1;
  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_AND  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_INV  = 5'd6;
  localparam logic [4:0] OP_EQ   = 5'd7;
  localparam logic [4:0] OP_LT   = 5'd8;
  localparam logic [4:0] OP_SHR  = 5'd9;
  localparam logic [4:0] OP_SHL  = 5'd10;
  localparam logic [4:0] OP_ULT  = 5'd11;
  localparam logic [4:0] OP_SUB  = 5'd12;
  localparam logic [4:0] OP_ASR  = 5'd13;
  localparam logic [4:0] OP_MULL = 5'd14;
  localparam logic [4:0] OP_MULH = 5'd15;
  localparam logic [4:0] OP_DIVU = 5'd16;
  localparam logic [4:0] OP_REMU = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    KIND_SINGLE = 2'd0,
    KIND_MUL    = 2'd1,
    KIND_DIV    = 2'd2
  } op_kind_t;

  // Reserved opcodes fall into the single-cycle class and evaluate to 0.
  function automatic op_kind_t classify_op(input logic [4:0] op);
    op_kind_t kind;
    case (op)
      OP_MULL, OP_MULH: kind = KIND_MUL;
      OP_DIVU, OP_REMU: kind = KIND_DIV;
      default:          kind = KIND_SINGLE;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/seq_muldiv_unit.sv
// seq_muldiv_unit
// Iterative multiply / unsigned divide engine sharing one iteration counter.
// Ports:
//   clk, reset     clock and asynchronous active-high reset
//   load           start a new operation with operands a, b
//   kind           0 = multiply (a*b), 1 = divide (a/b, a%b)
//   a, b           operands (a = N, b = T)
//   cancel         abort the running operation
//   last           the current cycle performs the final iteration
//   prod_hi/lo     product after this cycle's iteration
//   quot/rem       quotient / remainder after this cycle's iteration
// The result outputs show the value the registers take at the next edge, so
// the owner can capture the finished result on the same edge as the final
// iteration (when last is high).
module seq_muldiv_unit
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             kind,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             last,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  logic               active_q, active_d;
  logic               kind_q, kind_d;
  logic [SHW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]   operand_q, operand_d;
  logic [2*WIDTH-1:0] mul_acc_q, mul_acc_d;
  logic [WIDTH:0]     div_rem_q, div_rem_d;
  logic [WIDTH-1:0]   div_quot_q, div_quot_d;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_fits;
  logic [WIDTH:0]     div_rem_step;
  logic [WIDTH-1:0]   div_quot_step;

  // One iteration of each datapath. Multiply keeps the multiplier in the low
  // half of the accumulator and shifts the running sum in from the top.
  // Divide is restoring: shift in the next dividend bit, subtract the
  // divisor if it fits. A set remainder MSB always means the divisor fits.
  always_comb begin
    mul_sum       = {1'b0, mul_acc_q[2*WIDTH-1:WIDTH]}
                  + (mul_acc_q[0] ? {1'b0, operand_q} : '0);
    mul_step      = {mul_sum, mul_acc_q[WIDTH-1:1]};
    div_shift     = {div_rem_q[WIDTH-1:0], div_quot_q[WIDTH-1]};
    div_diff      = div_shift - {1'b0, operand_q};
    div_fits      = div_rem_q[WIDTH] || (div_shift >= {1'b0, operand_q});
    div_rem_step  = div_fits ? div_diff : div_shift;
    div_quot_step = {div_quot_q[WIDTH-2:0], div_fits};
  end

  assign last    = active_q && (count_q == SHW'(WIDTH - 1));
  assign prod_hi = mul_step[2*WIDTH-1:WIDTH];
  assign prod_lo = mul_step[WIDTH-1:0];
  assign quot    = div_quot_step;
  assign rem     = div_rem_step[WIDTH-1:0];

  // Load, iterate and retire control for the shared counter and datapaths.
  always_comb begin
    active_d   = active_q;
    kind_d     = kind_q;
    count_d    = count_q;
    operand_d  = operand_q;
    mul_acc_d  = mul_acc_q;
    div_rem_d  = div_rem_q;
    div_quot_d = div_quot_q;
    if (cancel) begin
      active_d = 1'b0;
      count_d  = '0;
    end else if (load) begin
      active_d = 1'b1;
      kind_d   = kind;
      count_d  = '0;
      if (kind) begin
        operand_d  = b;
        div_rem_d  = '0;
        div_quot_d = a;
      end else begin
        operand_d = a;
        mul_acc_d = {{WIDTH{1'b0}}, b};
      end
    end else if (active_q) begin
      count_d = count_q + 1'b1;
      if (kind_q) begin
        div_rem_d  = div_rem_step;
        div_quot_d = div_quot_step;
      end else begin
        mul_acc_d = mul_step;
      end
      if (last) begin
        active_d = 1'b0;
        count_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q   <= 1'b0;
      kind_q     <= 1'b0;
      count_q    <= '0;
      operand_q  <= '0;
      mul_acc_q  <= '0;
      div_rem_q  <= '0;
      div_quot_q <= '0;
    end else begin
      active_q   <= active_d;
      kind_q     <= kind_d;
      count_q    <= count_d;
      operand_q  <= operand_d;
      mul_acc_q  <= mul_acc_d;
      div_rem_q  <= div_rem_d;
      div_quot_q <= div_quot_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu
// Sequential ALU for the j2 stack core. Single-cycle T/N operations return a
// registered result one cycle after accept; MULL/MULH and DIVU/REMU iterate
// one bit per cycle in seq_muldiv_unit and hold busy meanwhile.
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   start           request, accepted when start && ready && !cancel
//   op, t_in, n_in  opcode and operands, captured at accept
//   cancel          synchronous abort back to IDLE
//   ready           high in IDLE and DONE
//   busy            high in MUL and DIV
//   done            one-cycle pulse with result valid
//   result          last result, held until the next done
//   div_by_zero     set with done for DIVU/REMU with T == 0
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] t_in,
  input  logic [WIDTH-1:0] n_in,
  input  logic             cancel,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dbz_q, dbz_d;
  logic             sel_alt_q, sel_alt_d;

  logic             accept;
  op_kind_t         op_kind;
  logic             md_load;
  logic             md_kind;
  logic             md_last;
  logic [WIDTH-1:0] md_prod_hi;
  logic [WIDTH-1:0] md_prod_lo;
  logic [WIDTH-1:0] md_quot;
  logic [WIDTH-1:0] md_rem;

  logic [WIDTH-1:0] alu_value;
  logic             shift_big;
  logic [SHW-1:0]   shamt;

  assign ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy   = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign div_by_zero = dbz_q;

  assign accept  = start && ready && !cancel;
  assign op_kind = classify_op(op);
  assign md_kind = (op_kind == KIND_DIV);

  seq_muldiv_unit #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .load    (md_load),
    .kind    (md_kind),
    .a       (n_in),
    .b       (t_in),
    .cancel  (cancel),
    .last    (md_last),
    .prod_hi (md_prod_hi),
    .prod_lo (md_prod_lo),
    .quot    (md_quot),
    .rem     (md_rem)
  );

  // Single-cycle datapath. Shift amounts of WIDTH or more saturate instead
  // of wrapping through the truncated shamt.
  always_comb begin
    shift_big = (t_in >= WIDTH'(WIDTH));
    shamt     = t_in[SHW-1:0];
    alu_value = '0;
    case (op)
      OP_T:    alu_value = t_in;
      OP_N:    alu_value = n_in;
      OP_ADD:  alu_value = t_in + n_in;
      OP_AND:  alu_value = t_in & n_in;
      OP_OR:   alu_value = t_in | n_in;
      OP_XOR:  alu_value = t_in ^ n_in;
      OP_INV:  alu_value = ~t_in;
      OP_EQ:   alu_value = {WIDTH{n_in == t_in}};
      OP_LT:   alu_value = {WIDTH{$signed(n_in) < $signed(t_in)}};
      OP_SHR:  alu_value = shift_big ? '0 : (n_in >> shamt);
      OP_SHL:  alu_value = shift_big ? '0 : (n_in << shamt);
      OP_ULT:  alu_value = {WIDTH{n_in < t_in}};
      OP_SUB:  alu_value = n_in - t_in;
      OP_ASR:  alu_value = shift_big ? {WIDTH{n_in[WIDTH-1]}}
                                     : $unsigned($signed(n_in) >>> shamt);
      default: alu_value = '0;
    endcase
  end

  // FSM and output register updates. sel_alt remembers op[0], which picks
  // the high product for MULH and the remainder for REMU.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    dbz_d     = dbz_q;
    sel_alt_d = sel_alt_q;
    md_load   = 1'b0;
    if (cancel) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            case (op_kind)
              KIND_MUL: begin
                state_d   = ST_MUL;
                md_load   = 1'b1;
                sel_alt_d = op[0];
              end
              KIND_DIV: begin
                if (t_in == '0) begin
                  state_d  = ST_DONE;
                  result_d = op[0] ? n_in : '1;
                  dbz_d    = 1'b1;
                end else begin
                  state_d   = ST_DIV;
                  md_load   = 1'b1;
                  sel_alt_d = op[0];
                end
              end
              default: begin
                state_d  = ST_DONE;
                result_d = alu_value;
                dbz_d    = 1'b0;
              end
            endcase
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MUL: begin
          if (md_last) begin
            state_d  = ST_DONE;
            result_d = sel_alt_q ? md_prod_hi : md_prod_lo;
            dbz_d    = 1'b0;
          end
        end
        ST_DIV: begin
          if (md_last) begin
            state_d  = ST_DONE;
            result_d = sel_alt_q ? md_rem : md_quot;
            dbz_d    = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      dbz_q     <= 1'b0;
      sel_alt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      dbz_q     <= dbz_d;
      sel_alt_q <= sel_alt_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu
// Directed and randomized bench for seq_alu at WIDTH = 16. Expected results
// come from a plain-arithmetic model of the opcode table.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  op;
  logic [15:0] t_in;
  logic [15:0] n_in;
  logic        cancel;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        div_by_zero;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .t_in        (t_in),
    .n_in        (n_in),
    .cancel      (cancel),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  // Reference model of the opcode table using plain integer arithmetic.
  function automatic int modelResult(input int o, input int n, input int t);
    longint p;
    int sn;
    int st;
    p  = longint'(n) * longint'(t);
    sn = (n >= 32768) ? n - 65536 : n;
    st = (t >= 32768) ? t - 65536 : t;
    case (o)
      0:  return t;
      1:  return n;
      2:  return (t + n) & 'hFFFF;
      3:  return t & n;
      4:  return t | n;
      5:  return t ^ n;
      6:  return (~t) & 'hFFFF;
      7:  return (n == t) ? 'hFFFF : 0;
      8:  return (sn < st) ? 'hFFFF : 0;
      9:  return (t >= 16) ? 0 : (n >> t);
      10: return (t >= 16) ? 0 : ((n << t) & 'hFFFF);
      11: return (n < t) ? 'hFFFF : 0;
      12: return (n - t) & 'hFFFF;
      13: return (sn >>> ((t >= 16) ? 15 : t)) & 'hFFFF;
      14: return int'(p & 'hFFFF);
      15: return int'((p >> 16) & 'hFFFF);
      16: return (t == 0) ? 'hFFFF : n / t;
      17: return (t == 0) ? n : n % t;
      default: return 0;
    endcase
  endfunction

  function automatic int modelLatency(input int o, input int t);
    if (o == 14 || o == 15) return 17;
    if ((o == 16 || o == 17) && t != 0) return 17;
    return 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and waits (bounded) for done. poke != 0 pulses start
  // again in that cycle after accept, while the block should be busy.
  task automatic applyStimulus(input logic [4:0] o, input logic [15:0] n,
                               input logic [15:0] t, input int poke,
                               output logic [15:0] res, output logic dbz,
                               output int cycles, output int busy_cycles);
    int guard;
    guard = 0;
    while (!ready && guard < 40) begin
      stepCycle();
      guard++;
    end
    op    = o;
    n_in  = n;
    t_in  = t;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    cycles = 1;
    busy_cycles = 0;
    while (!done && cycles < 40) begin
      if (busy) busy_cycles++;
      start = (cycles == poke);
      stepCycle();
      start = 1'b0;
      cycles++;
    end
    res = result;
    dbz = div_by_zero;
  endtask

  task automatic runAndCheck(input string tag, input logic [4:0] o,
                             input logic [15:0] n, input logic [15:0] t,
                             input logic [15:0] exp_res, input logic exp_dbz,
                             input int poke);
    logic [15:0] res;
    logic dbz;
    int cycles;
    int busy_cycles;
    int lat;
    applyStimulus(o, n, t, poke, res, dbz, cycles, busy_cycles);
    lat = modelLatency(int'(o), int'(t));
    checkOutput({tag, "_result"}, res, exp_res);
    checkOutput({tag, "_dbz"}, dbz, exp_dbz);
    checkOutput({tag, "_latency"}, cycles, lat);
    checkOutput({tag, "_busy_cycles"}, busy_cycles, lat - 1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, ready, 1);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_result"}, result, 0);
    checkOutput({tag, "_dbz"}, div_by_zero, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int done_count;
    int o;
    int n;
    int t;
    reset  = 1'b1;
    start  = 1'b0;
    cancel = 1'b0;
    op     = '0;
    t_in   = '0;
    n_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkResetValues("reset");

    $display("[TB] single-cycle directed ops");
    runAndCheck("add_wrap", 5'd2, 16'hFFFF, 16'h0002, 16'h0001, 1'b0, 0);
    runAndCheck("slt", 5'd8, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 0);
    runAndCheck("ult", 5'd11, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 0);
    runAndCheck("shr_big", 5'd9, 16'h8000, 16'd20, 16'h0000, 1'b0, 0);
    runAndCheck("asr_big", 5'd13, 16'h8000, 16'd20, 16'hFFFF, 1'b0, 0);
    runAndCheck("shl_big", 5'd10, 16'h8000, 16'd20, 16'h0000, 1'b0, 0);
    runAndCheck("asr_3", 5'd13, 16'h8000, 16'd3, 16'hF000, 1'b0, 0);
    runAndCheck("reserved", 5'd25, 16'h1234, 16'h5678, 16'h0000, 1'b0, 0);

    $display("[TB] multiply and divide");
    runAndCheck("mull", 5'd14, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 0);
    runAndCheck("mulh_poke", 5'd15, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 4);
    stepCycle();
    checkOutput("mulh_no_extra_done", done, 0);
    runAndCheck("divu", 5'd16, 16'd100, 16'd7, 16'd14, 1'b0, 0);
    runAndCheck("remu", 5'd17, 16'd100, 16'd7, 16'd2, 1'b0, 0);
    runAndCheck("divu_zero", 5'd16, 16'h1234, 16'h0000, 16'hFFFF, 1'b1, 0);
    runAndCheck("remu_zero", 5'd17, 16'h1234, 16'h0000, 16'h1234, 1'b1, 0);
    runAndCheck("dbz_clear", 5'd0, 16'h0000, 16'h00AA, 16'h00AA, 1'b0, 0);

    $display("[TB] cancel behaviour");
    runAndCheck("pre_cancel", 5'd2, 16'h0000, 16'h1111, 16'h1111, 1'b0, 0);
    op    = 5'd14;
    n_in  = 16'd3;
    t_in  = 16'd5;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    repeat (4) stepCycle();
    cancel = 1'b1;
    stepCycle();
    cancel = 1'b0;
    checkOutput("cancel_busy", busy, 0);
    checkOutput("cancel_done", done, 0);
    checkOutput("cancel_ready", ready, 1);
    checkOutput("cancel_result", result, 16'h1111);
    done_count = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) done_count++;
      stepCycle();
    end
    checkOutput("cancel_no_done", done_count, 0);

    op     = 5'd2;
    n_in   = 16'd1;
    t_in   = 16'd1;
    start  = 1'b1;
    cancel = 1'b1;
    stepCycle();
    start  = 1'b0;
    cancel = 1'b0;
    checkOutput("cancel_start_done", done, 0);
    checkOutput("cancel_start_busy", busy, 0);
    checkOutput("cancel_start_result", result, 16'h1111);

    $display("[TB] asynchronous reset during divide");
    runAndCheck("pre_reset", 5'd2, 16'd5, 16'd3, 16'd8, 1'b0, 0);
    op    = 5'd16;
    n_in  = 16'd100;
    t_in  = 16'd7;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    repeat (3) stepCycle();
    checkOutput("div_busy_before_reset", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    checkResetValues("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    runAndCheck("post_reset_add", 5'd2, 16'd40, 16'd2, 16'd42, 1'b0, 0);

    $display("[TB] randomized ops against the model");
    for (int i = 0; i < 150; i++) begin
      o = int'($urandom_range(0, 31));
      n = int'($urandom & 32'hFFFF);
      case ($urandom_range(0, 3))
        0: t = int'($urandom_range(0, 20));
        1: t = (o == 16 || o == 17) ? 0 : int'($urandom & 32'hFFFF);
        default: t = int'($urandom & 32'hFFFF);
      endcase
      runAndCheck($sformatf("rand%0d_op%0d", i, o), 5'(o), 16'(n), 16'(t),
                  16'(modelResult(o, n, t)),
                  ((o == 16 || o == 17) && t == 0), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
